// File: rtl/psinr_status_sink_if.sv
// psinr_status_sink_if: bundles the snooped cfg handshake, the three status
// streams and the per-job report / counter outputs of psinr_status_sink.
// The slave modport is the sink's view; the master modport is the view of
// whatever drives the status streams and reads the report.
interface psinr_status_sink_if #(
    parameter int CNT_W = 16
) ();
    logic             comb_cfg_valid;
    logic             comb_cfg_ready;
    logic             comb_status_tvalid;
    logic [11:0]      comb_status_tdata;
    logic             comb_status_tready;
    logic             psinr_calc_status_tvalid;
    logic [9:0]       psinr_calc_status_tdata;
    logic             psinr_calc_status_tready;
    logic             psinr_out_status_tvalid;
    logic [6:0]       psinr_out_status_tdata;
    logic             psinr_out_status_tready;
    logic             rpt_valid;
    logic [1:0]       rpt_err;
    logic [11:0]      rpt_comb;
    logic [9:0]       rpt_calc;
    logic [6:0]       rpt_out;
    logic [CNT_W-1:0] ok_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport slave (
        input  comb_cfg_valid, comb_cfg_ready,
        input  comb_status_tvalid, comb_status_tdata,
        output comb_status_tready,
        input  psinr_calc_status_tvalid, psinr_calc_status_tdata,
        output psinr_calc_status_tready,
        input  psinr_out_status_tvalid, psinr_out_status_tdata,
        output psinr_out_status_tready,
        output rpt_valid, rpt_err, rpt_comb, rpt_calc, rpt_out,
        output ok_cnt, err_cnt
    );

    modport master (
        output comb_cfg_valid, comb_cfg_ready,
        output comb_status_tvalid, comb_status_tdata,
        input  comb_status_tready,
        output psinr_calc_status_tvalid, psinr_calc_status_tdata,
        input  psinr_calc_status_tready,
        output psinr_out_status_tvalid, psinr_out_status_tdata,
        input  psinr_out_status_tready,
        input  rpt_valid, rpt_err, rpt_comb, rpt_calc, rpt_out,
        input  ok_cnt, err_cnt
    );
endinterface

// File: rtl/psinr_status_sink.sv
// psinr_status_sink: tracks one PSINR job from the snooped cfg handshake
// through the comb, calc and out status beats (in that order), flags
// ordering / overlap / timeout problems, emits a one-cycle report and keeps
// saturating ok / error job counters.
module psinr_status_sink #(
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = 4096,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                arst_n,
    psinr_status_sink_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_COMB = 3'd1,
        ST_W_CALC = 3'd2,
        ST_W_OUT  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    // Saturating +1 for the job counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t           state_r, state_next_s;
    logic [TMO_W-1:0] timer_r, timer_next_s;
    logic [1:0]       err_r, err_next_s;
    logic [11:0]      comb_r;
    logic [9:0]       calc_r;
    logic [6:0]       out_r;
    logic             rpt_valid_r;
    logic             tready_r;
    logic [CNT_W-1:0] ok_cnt_r, err_cnt_r;

    logic cfg_hs_s, comb_beat_s, calc_beat_s, out_beat_s;
    logic job_start_s, in_wait_s, exp_s, unexp_s;
    logic cap_comb_s, cap_calc_s, cap_out_s;
    state_t adv_state_s;

    // A beat counts only when the sink is offering tready; cfg is snooped.
    assign cfg_hs_s    = bus.comb_cfg_valid & bus.comb_cfg_ready;
    assign comb_beat_s = bus.comb_status_tvalid & tready_r;
    assign calc_beat_s = bus.psinr_calc_status_tvalid & tready_r;
    assign out_beat_s  = bus.psinr_out_status_tvalid & tready_r;

    // Next-state, error, timer and capture decisions.
    always_comb begin
        state_next_s = state_r;
        err_next_s   = err_r;
        timer_next_s = timer_r;
        job_start_s  = 1'b0;
        in_wait_s    = 1'b0;
        exp_s        = 1'b0;
        unexp_s      = 1'b0;
        adv_state_s  = state_r;
        cap_comb_s   = 1'b0;
        cap_calc_s   = 1'b0;
        cap_out_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Beats in IDLE are consumed and dropped.
                if (cfg_hs_s) begin
                    job_start_s = 1'b1;
                end else begin
                    job_start_s = 1'b0;
                end
            end
            ST_W_COMB: begin
                in_wait_s   = 1'b1;
                exp_s       = comb_beat_s;
                unexp_s     = calc_beat_s | out_beat_s;
                adv_state_s = ST_W_CALC;
                cap_comb_s  = comb_beat_s;
            end
            ST_W_CALC: begin
                in_wait_s   = 1'b1;
                exp_s       = calc_beat_s;
                unexp_s     = comb_beat_s | out_beat_s;
                adv_state_s = ST_W_OUT;
                cap_calc_s  = calc_beat_s;
            end
            ST_W_OUT: begin
                in_wait_s   = 1'b1;
                exp_s       = out_beat_s;
                unexp_s     = comb_beat_s | calc_beat_s;
                adv_state_s = ST_REPORT;
                cap_out_s   = out_beat_s;
            end
            ST_REPORT: begin
                // cfg handshakes here are ignored, not treated as overlap.
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        if (job_start_s) begin
            state_next_s = ST_W_COMB;
            err_next_s   = 2'd0;
            timer_next_s = {TMO_W{1'b0}};
        end else if (in_wait_s) begin
            // First error wins; a timeout below overrides it.
            if (err_r != 2'd0) begin
                err_next_s = err_r;
            end else if (unexp_s) begin
                err_next_s = 2'd2;
            end else if (cfg_hs_s) begin
                err_next_s = 2'd3;
            end else begin
                err_next_s = err_r;
            end
            // The expected beat beats a same-cycle timeout.
            if (exp_s) begin
                state_next_s = adv_state_s;
                timer_next_s = {TMO_W{1'b0}};
            end else if (timer_r == TMO_LAST) begin
                err_next_s   = 2'd1;
                state_next_s = ST_REPORT;
                timer_next_s = {TMO_W{1'b0}};
            end else begin
                timer_next_s = timer_r + {{(TMO_W-1){1'b0}}, 1'b1};
            end
        end else begin
            timer_next_s = timer_r;
        end
    end

    // FSM state, timer and error register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= ST_IDLE;
            timer_r <= {TMO_W{1'b0}};
            err_r   <= 2'd0;
        end else begin
            state_r <= state_next_s;
            timer_r <= timer_next_s;
            err_r   <= err_next_s;
        end
    end

    // Captured payloads: cleared at job start, held until the next job.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            comb_r <= 12'd0;
            calc_r <= 10'd0;
            out_r  <= 7'd0;
        end else if (job_start_s) begin
            comb_r <= 12'd0;
            calc_r <= 10'd0;
            out_r  <= 7'd0;
        end else begin
            if (cap_comb_s) comb_r <= bus.comb_status_tdata;
            if (cap_calc_s) calc_r <= bus.psinr_calc_status_tdata;
            if (cap_out_s)  out_r  <= bus.psinr_out_status_tdata;
        end
    end

    // Registered report strobe and ready; ready drops only for REPORT.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rpt_valid_r <= 1'b0;
            tready_r    <= 1'b0;
        end else begin
            rpt_valid_r <= (state_next_s == ST_REPORT);
            tready_r    <= (state_next_s != ST_REPORT);
        end
    end

    // Job counters bump on entry to REPORT so they line up with rpt_valid.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ok_cnt_r  <= {CNT_W{1'b0}};
            err_cnt_r <= {CNT_W{1'b0}};
        end else if (state_next_s == ST_REPORT && state_r != ST_REPORT) begin
            if (err_next_s == 2'd0) begin
                ok_cnt_r <= sat_inc(ok_cnt_r);
            end else begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end
        end else begin
            ok_cnt_r  <= ok_cnt_r;
            err_cnt_r <= err_cnt_r;
        end
    end

    assign bus.comb_status_tready       = tready_r;
    assign bus.psinr_calc_status_tready = tready_r;
    assign bus.psinr_out_status_tready  = tready_r;
    assign bus.rpt_valid                = rpt_valid_r;
    assign bus.rpt_err                  = err_r;
    assign bus.rpt_comb                 = comb_r;
    assign bus.rpt_calc                 = calc_r;
    assign bus.rpt_out                  = out_r;
    assign bus.ok_cnt                   = ok_cnt_r;
    assign bus.err_cnt                  = err_cnt_r;
endmodule

// File: doc/psinr_status_sink.md
Name: psinr_status_sink

Overview:
- Receiving end of the comb/PSINR status streams.
- Snoops the comb_cfg handshake to learn that a job has started.
- Accepts exactly one beat each from the comb, psinr_calc and psinr_out status streams, in that order. Checks ordering and timeout.
- Emits one per-job report and keeps saturating ok/error job counters. Sits between the PSINR datapath status outputs and the host register/monitor logic.

Parameters:
- TMO_W, 16, width of the per-stage timeout counter.
- TMO_CYC, 4096, cycles allowed between stage entry and the expected beat (1..2^TMO_W-1).
- CNT_W, 16, width of the job counters.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- comb_cfg_valid  in  1  snooped cfg valid
- comb_cfg_ready  in  1  snooped cfg ready; handshake = valid & ready
- comb_status_tvalid  in  1  comb status beat valid
- comb_status_tdata  in  12  comb status payload
- comb_status_tready  out  1  comb status accept
- psinr_calc_status_tvalid  in  1  calc status beat valid
- psinr_calc_status_tdata  in  10  calc status payload
- psinr_calc_status_tready  out  1  calc status accept
- psinr_out_status_tvalid  in  1  out status beat valid
- psinr_out_status_tdata  in  7  out status payload
- psinr_out_status_tready  out  1  out status accept
- rpt_valid  out  1  one-cycle report strobe
- rpt_err  out  2  0 none, 1 timeout, 2 unexpected/out-of-order beat, 3 cfg overlap
- rpt_comb  out  12  captured comb status
- rpt_calc  out  10  captured calc status
- rpt_out  out  7  captured out status
- ok_cnt  out  CNT_W  jobs reported with rpt_err=0, saturating
- err_cnt  out  CNT_W  jobs reported with rpt_err!=0, saturating

Behaviour:
- Reset (async assert, sync deassert internally is not required): all outputs 0, state IDLE, timer 0, captured regs 0, error reg 0. Reset mid-job drops the job silently; no report, counters cleared.
- States: IDLE, W_COMB, W_CALC, W_OUT, REPORT.
- All three tready are 1 in every state except REPORT, where all are 0. Every beat is therefore consumed, and none is accepted during REPORT.
- IDLE: a cfg handshake moves to W_COMB and clears captured regs, error reg and timer. A status beat in IDLE is consumed and ignored; no report and no count.
- W_COMB: a comb beat captures rpt_comb and moves to W_CALC.
- W_CALC: a calc beat captures rpt_calc and moves to W_OUT.
- W_OUT: an out beat captures rpt_out and moves to REPORT.
- Unexpected stream in a W_* state: the beat is consumed and not captured. Error is set to 2 if the error reg is still 0. The state does not change.
- Simultaneous beats: the expected stream is processed as a normal transition. Any other concurrent beat is treated as unexpected (error 2 if none yet).
- Cfg handshake while not IDLE: error 3 if none yet. No restart and no state change.
- Timer:
  - Cleared on entry to each W_* state; increments every cycle in a W_* state.
  - Reaching TMO_CYC-1 without the expected beat sets error 1 (overrides any earlier error) and moves to REPORT.
  - If the expected beat arrives on that same cycle, the beat wins and there is no timeout.
- Error reg is first-error-wins, except that timeout always overrides.
- REPORT, one cycle:
  - rpt_valid=1.
  - rpt_err shows the error reg; rpt_* hold the captured values (0 for stages not reached).
  - Increment ok_cnt or err_cnt, saturating at all-ones.
  - Always return to IDLE. A cfg handshake in REPORT is ignored, not counted as overlap.
- rpt_* registers hold their values until the next job start. rpt_valid is 0 outside REPORT.
- Latency: rpt_valid is asserted exactly 1 cycle after the cycle the out beat is accepted.

Test Plan:
- Cfg handshake at t0; comb beat 0xABC at t2, calc beat 0x155 at t4, out beat 0x2A at t6 -> rpt_valid at t7, rpt_err=0, rpt_comb=0xABC, rpt_calc=0x155, rpt_out=0x2A, ok_cnt=1.
- Cfg handshake, then calc beat before comb, then correct comb/calc/out sequence -> single report with rpt_err=2, err_cnt=1.
- TMO_CYC=8; cfg handshake, comb beat, no calc beat -> report 8 cycles after W_CALC entry; rpt_err=1, rpt_comb captured, rpt_calc=0, rpt_out=0.
- Second cfg handshake during W_CALC, then sequence completes -> rpt_err=3, exactly one report, state IDLE afterwards.
- Comb and calc beats in the same cycle in W_COMB -> comb captured, rpt_err=2; with err_cnt preset to all-ones, err_cnt stays all-ones (saturation).
- arst_n low while in W_OUT -> all outputs 0 immediately, no rpt_valid; the next full job reports ok_cnt=1.
